// File: rtl/cpu_sram_arbiter.sv
// cpu_sram_arbiter
// Shares one synchronous single-port SRAM (1-cycle read latency) between an
// instruction requester and a data requester. Data wins ties, except that
// after STARVE_LIMIT consecutive data grants while inst_req waits, inst is
// forced through. Grants are combinational; the response phase (data_ok)
// follows exactly one cycle after the grant and is tracked by a small FSM.
//
//   state    | meaning
//   ---------+--------------------------------------------------------------
//   S_IDLE   | no access issued last cycle, no response this cycle
//   S_RESP_I | inst access issued last cycle, inst_data_ok this cycle
//   S_RESP_D | data access issued last cycle, data_data_ok this cycle
//
// Back-to-back accesses are allowed: a new grant may be issued in any RESP
// cycle, so throughput is one access per cycle.

module cpu_sram_arbiter #(
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic        clk,
  input  logic        resetn,

  input  logic        inst_req,
  input  logic        inst_wr,
  input  logic [3:0]  inst_wstrb,
  input  logic [31:0] inst_addr,
  input  logic [31:0] inst_wdata,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [31:0] inst_rdata,

  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,

  output logic        sram_en,
  output logic [3:0]  sram_wen,
  output logic [31:0] sram_addr,
  output logic [31:0] sram_wdata,
  input  logic [31:0] sram_rdata
);

  // A zero limit still needs a one-bit counter to keep the logic well formed.
  localparam int unsigned CNT_W = (STARVE_LIMIT < 1) ? 1 : $clog2(STARVE_LIMIT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(STARVE_LIMIT);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_RESP_I = 2'd1,
    S_RESP_D = 2'd2
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] starve_q, starve_d;
  logic             gnt_inst, gnt_data;
  logic             starved;

  assign starved = (starve_q == CNT_MAX);

  // Grant selection: nothing in reset, sole requester wins, data wins ties
  // unless inst has been passed over STARVE_LIMIT times in a row.
  always_comb begin
    gnt_inst = 1'b0;
    gnt_data = 1'b0;
    if (resetn) begin
      if (inst_req && data_req) begin
        if (starved) begin
          gnt_inst = 1'b1;
        end else begin
          gnt_data = 1'b1;
        end
      end else begin
        gnt_inst = inst_req;
        gnt_data = data_req;
      end
    end
  end

  // State register and starvation counter, synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      starve_q <= '0;
    end else begin
      state_q  <= state_d;
      starve_q <= starve_d;
    end
  end

  // Next state: the response phase always reflects last cycle's grant.
  always_comb begin
    state_d = S_IDLE;
    if (gnt_inst) begin
      state_d = S_RESP_I;
    end else if (gnt_data) begin
      state_d = S_RESP_D;
    end
  end

  // Starvation counter: counts data grants that bypassed a waiting inst_req;
  // any inst grant or an idle inst side clears it, and it saturates.
  always_comb begin
    starve_d = starve_q;
    if (gnt_inst || !inst_req) begin
      starve_d = '0;
    end else if (gnt_data && !starved) begin
      starve_d = starve_q + 1'b1;
    end
  end

  // Outputs: address-phase handshake and SRAM drive from the grant,
  // response-phase strobes from the state.
  always_comb begin
    inst_addr_ok = gnt_inst;
    data_addr_ok = gnt_data;
    sram_en      = gnt_inst | gnt_data;
    sram_wen     = 4'b0000;
    sram_addr    = 32'h0000_0000;
    sram_wdata   = 32'h0000_0000;
    if (gnt_inst) begin
      sram_wen   = inst_wr ? inst_wstrb : 4'b0000;
      sram_addr  = inst_addr;
      sram_wdata = inst_wdata;
    end else if (gnt_data) begin
      sram_wen   = data_wr ? data_wstrb : 4'b0000;
      sram_addr  = data_addr;
      sram_wdata = data_wdata;
    end

    inst_data_ok = 1'b0;
    data_data_ok = 1'b0;
    case (state_q)
      S_RESP_I: inst_data_ok = 1'b1;
      S_RESP_D: data_data_ok = 1'b1;
      default:  ;
    endcase
  end

  // Read data is a straight pass-through; qualified by the data_ok strobes.
  assign inst_rdata = sram_rdata;
  assign data_rdata = sram_rdata;

endmodule

// File: tb/tb_cpu_sram_arbiter.sv
// Testbench for cpu_sram_arbiter: directed scenarios followed by random
// traffic. A reference model predicts each cycle's grant and pushes the
// expected response into a queue; an independent monitor pops and compares
// whenever a response is due or the DUT shows one.

module tb_cpu_sram_arbiter;

  localparam int LIM = 4;

  logic        clk = 1'b0;
  logic        resetn;
  logic        inst_req, inst_wr, data_req, data_wr;
  logic [3:0]  inst_wstrb, data_wstrb;
  logic [31:0] inst_addr, inst_wdata, data_addr, data_wdata;
  logic        inst_addr_ok, inst_data_ok, data_addr_ok, data_data_ok;
  logic [31:0] inst_rdata, data_rdata;
  logic        sram_en;
  logic [3:0]  sram_wen;
  logic [31:0] sram_addr, sram_wdata;
  logic [31:0] sram_rdata = 32'h0;

  int checks = 0;
  int failures = 0;
  int cycle_cnt = 0;
  bit run = 1'b0;

  cpu_sram_arbiter #(.STARVE_LIMIT(LIM)) dut (
    .clk          (clk),
    .resetn       (resetn),
    .inst_req     (inst_req),
    .inst_wr      (inst_wr),
    .inst_wstrb   (inst_wstrb),
    .inst_addr    (inst_addr),
    .inst_wdata   (inst_wdata),
    .inst_addr_ok (inst_addr_ok),
    .inst_data_ok (inst_data_ok),
    .inst_rdata   (inst_rdata),
    .data_req     (data_req),
    .data_wr      (data_wr),
    .data_wstrb   (data_wstrb),
    .data_addr    (data_addr),
    .data_wdata   (data_wdata),
    .data_addr_ok (data_addr_ok),
    .data_data_ok (data_data_ok),
    .data_rdata   (data_rdata),
    .sram_en      (sram_en),
    .sram_wen     (sram_wen),
    .sram_addr    (sram_addr),
    .sram_wdata   (sram_wdata),
    .sram_rdata   (sram_rdata)
  );

  always #5 clk = ~clk;

  initial forever begin
    @(posedge clk);
    cycle_cnt++;
  end

  // Contents of never-written words: a fixed function of the address.
  function automatic logic [31:0] init_word(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h5A5A_0F0F;
  endfunction

  // ---------------- SRAM model (environment) ----------------
  logic [31:0] smem [logic [31:0]];
  logic        s_en;
  logic [3:0]  s_wen;
  logic [31:0] s_addr, s_wdata, s_key, s_word;

  initial forever begin
    @(negedge clk);
    s_en = sram_en; s_wen = sram_wen; s_addr = sram_addr; s_wdata = sram_wdata;
    @(posedge clk);
    if (s_en) begin
      s_key = s_addr & ~32'h3;
      s_word = smem.exists(s_key) ? smem[s_key] : init_word(s_key);
      sram_rdata = s_word;
      for (int b = 0; b < 4; b++)
        if (s_wen[b]) s_word[8*b +: 8] = s_wdata[8*b +: 8];
      if (s_wen != 4'b0) smem[s_key] = s_word;
    end
  end

  // ---------------- reference model ----------------
  typedef struct {
    int          cyc;
    bit          is_inst;
    bit          is_wr;
    logic [31:0] rdata;
  } exp_t;

  exp_t        exp_q[$];
  logic [31:0] rmem [logic [31:0]];
  int          sc_model = 0;
  int          g;
  logic        g_wr;
  logic [3:0]  g_strb;
  logic [31:0] g_addr, g_wdata, r_key, r_word;
  exp_t        e_new;

  function automatic logic [31:0] ref_read(input logic [31:0] a);
    logic [31:0] k;
    k = a & ~32'h3;
    return rmem.exists(k) ? rmem[k] : init_word(k);
  endfunction

  // Predict this cycle's grant and SRAM drive; queue the response for next cycle.
  initial forever begin
    @(negedge clk);
    if (run) begin
      g = 0;
      if (resetn) begin
        if (inst_req && data_req) g = (sc_model == LIM) ? 1 : 2;
        else if (inst_req)        g = 1;
        else if (data_req)        g = 2;
      end
      g_wr    = (g == 1) ? inst_wr    : (g == 2) ? data_wr    : 1'b0;
      g_strb  = (g == 1) ? inst_wstrb : (g == 2) ? data_wstrb : 4'b0;
      g_addr  = (g == 1) ? inst_addr  : (g == 2) ? data_addr  : 32'h0;
      g_wdata = (g == 1) ? inst_wdata : (g == 2) ? data_wdata : 32'h0;
      if (!g_wr) g_strb = 4'b0;
      checks++;
      if (inst_addr_ok !== (g == 1) || data_addr_ok !== (g == 2) || sram_en !== (g != 0) ||
          sram_wen !== g_strb || sram_addr !== g_addr || sram_wdata !== g_wdata) begin
        failures++;
        $display("FAIL addr_phase cyc=%0d: got iok=%b dok=%b en=%b wen=%h addr=%h wdata=%h expected grant=%0d wen=%h addr=%h wdata=%h",
                 cycle_cnt, inst_addr_ok, data_addr_ok, sram_en, sram_wen, sram_addr, sram_wdata,
                 g, g_strb, g_addr, g_wdata);
      end
      if (g != 0) begin
        e_new.cyc     = cycle_cnt + 1;
        e_new.is_inst = (g == 1);
        e_new.is_wr   = g_wr;
        e_new.rdata   = g_wr ? 32'h0 : ref_read(g_addr);
        exp_q.push_back(e_new);
        if (g_wr) begin
          r_key  = g_addr & ~32'h3;
          r_word = ref_read(r_key);
          for (int b = 0; b < 4; b++)
            if (g_strb[b]) r_word[8*b +: 8] = g_wdata[8*b +: 8];
          rmem[r_key] = r_word;
        end
      end
      // Data grants that pass over a waiting inst request, since inst last won.
      if (!resetn || g == 1 || !inst_req) sc_model = 0;
      else if (g == 2 && sc_model < LIM) sc_model++;
    end
  end

  // ---------------- response monitor ----------------
  exp_t        e_cur;
  logic [31:0] got_rd;

  initial forever begin
    @(negedge clk);
    if (run) begin
      checks++;
      if (inst_rdata !== sram_rdata || data_rdata !== sram_rdata) begin
        failures++;
        $display("FAIL rdata_pass: got i=%h d=%h expected %h", inst_rdata, data_rdata, sram_rdata);
      end
      while (exp_q.size() > 0 && exp_q[0].cyc < cycle_cnt) begin
        e_cur = exp_q.pop_front();
        checks++; failures++;
        $display("FAIL stale_resp: expected response at cyc=%0d never checked", e_cur.cyc);
      end
      checks++;
      if (exp_q.size() > 0 && exp_q[0].cyc == cycle_cnt) begin
        e_cur  = exp_q.pop_front();
        got_rd = e_cur.is_inst ? inst_rdata : data_rdata;
        if (inst_data_ok !== e_cur.is_inst || data_data_ok !== !e_cur.is_inst ||
            (!e_cur.is_wr && got_rd !== e_cur.rdata)) begin
          failures++;
          $display("FAIL resp cyc=%0d: got iok=%b dok=%b rdata=%h expected inst=%b wr=%b rdata=%h",
                   cycle_cnt, inst_data_ok, data_data_ok, got_rd, e_cur.is_inst, e_cur.is_wr, e_cur.rdata);
        end
      end else if (inst_data_ok || data_data_ok) begin
        failures++;
        $display("FAIL spurious_resp cyc=%0d: got iok=%b dok=%b expected 0 0",
                 cycle_cnt, inst_data_ok, data_data_ok);
      end
    end
  end

  // ---------------- directed helpers ----------------
  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] pick_addr();
    logic [31:0] base;
    base = ($urandom_range(0, 1) == 0) ? 32'hBFC0_0000 : 32'h1000_0000;
    return base + (32'($urandom_range(0, 7)) << 2);
  endfunction

  logic        i_acc, d_acc;
  logic [31:0] w_a, exp_a, exp_b;

  initial begin
    resetn = 1'b0;
    inst_req = 0; inst_wr = 0; inst_wstrb = 0; inst_addr = 0; inst_wdata = 0;
    data_req = 0; data_wr = 0; data_wstrb = 0; data_addr = 0; data_wdata = 0;
    repeat (3) @(posedge clk);
    #1;
    run = 1'b1;

    // Reset state, with requests pending
    inst_req = 1; data_req = 1;
    @(negedge clk);
    chk("rst_addr_ok", {30'b0, inst_addr_ok, data_addr_ok}, 32'h0);
    chk("rst_sram_en", {31'b0, sram_en}, 32'h0);
    chk("rst_sram_wen", {28'b0, sram_wen}, 32'h0);
    chk("rst_data_ok", {30'b0, inst_data_ok, data_data_ok}, 32'h0);
    tick();
    resetn = 1; inst_req = 0; data_req = 0;
    tick();

    // Inst-only read
    inst_req = 1; inst_wr = 0; inst_addr = 32'hBFC0_0000;
    @(negedge clk);
    chk("iread_addr_ok", {30'b0, inst_addr_ok, data_addr_ok}, 32'h2);
    chk("iread_sram_en", {31'b0, sram_en}, 32'h1);
    chk("iread_sram_addr", sram_addr, 32'hBFC0_0000);
    chk("iread_sram_wen", {28'b0, sram_wen}, 32'h0);
    tick();

    // Data write issued in the inst response cycle
    inst_req = 0;
    data_req = 1; data_wr = 1; data_wstrb = 4'b0011; data_addr = 32'h1000_0004; data_wdata = 32'h1234_5678;
    @(negedge clk);
    chk("iread_data_ok", {31'b0, inst_data_ok}, 32'h1);
    chk("iread_rdata", inst_rdata, init_word(32'hBFC0_0000));
    chk("dwr_addr_ok", {30'b0, inst_addr_ok, data_addr_ok}, 32'h1);
    chk("dwr_sram_wen", {28'b0, sram_wen}, 32'h3);
    chk("dwr_sram_wdata", sram_wdata, 32'h1234_5678);
    tick();
    data_req = 0; data_wr = 0; data_wstrb = 0;
    @(negedge clk);
    chk("dwr_data_ok", {30'b0, inst_data_ok, data_data_ok}, 32'h1);
    tick();
    tick();

    // Tie and starvation: pattern D D D D I D D D D I
    inst_req = 1; inst_addr = 32'hBFC0_0004;
    data_req = 1; data_addr = 32'h1000_0008;
    for (int k = 0; k < 10; k++) begin
      @(negedge clk);
      chk($sformatf("starve_grant_%0d", k), {30'b0, inst_addr_ok, data_addr_ok},
          (k % 5 == 4) ? 32'h2 : 32'h1);
      if (k == 1) chk("tie_resp_d", {30'b0, inst_data_ok, data_data_ok}, 32'h1);
      if (k == 5) chk("starve_resp_i", {30'b0, inst_data_ok, data_data_ok}, 32'h2);
      tick();
    end
    inst_req = 0; data_req = 0;
    tick();

    // Back-to-back data reads A then B
    w_a   = init_word(32'h1000_0004);
    exp_a = {w_a[31:16], 16'h5678};
    exp_b = init_word(32'h1000_000C);
    data_req = 1; data_wr = 0; data_addr = 32'h1000_0004;
    tick();
    data_addr = 32'h1000_000C;
    @(negedge clk);
    chk("b2b_ok_a", {31'b0, data_data_ok}, 32'h1);
    chk("b2b_rdata_a", data_rdata, exp_a);
    tick();
    data_req = 0;
    @(negedge clk);
    chk("b2b_ok_b", {31'b0, data_data_ok}, 32'h1);
    chk("b2b_rdata_b", data_rdata, exp_b);
    tick();
    tick();

    // Reset in the inst response cycle
    inst_req = 1; inst_wr = 0; inst_addr = 32'hBFC0_0008;
    @(negedge clk);
    chk("rmid_grant", {31'b0, inst_addr_ok}, 32'h1);
    tick();
    inst_req = 0; resetn = 0;
    @(negedge clk);
    chk("rmid_sram_en", {31'b0, sram_en}, 32'h0);
    tick();
    resetn = 1;
    @(negedge clk);
    chk("rmid_no_data_ok", {30'b0, inst_data_ok, data_data_ok}, 32'h0);
    chk("rmid_outputs", {26'b0, inst_addr_ok, data_addr_ok, sram_en, sram_wen == 4'b0 ? 1'b0 : 1'b1, 2'b0}, 32'h0);
    tick();

    // Random traffic; payload held until accepted
    for (int n = 0; n < 3000; n++) begin
      @(negedge clk);
      i_acc = inst_addr_ok;
      d_acc = data_addr_ok;
      tick();
      resetn = ($urandom_range(0, 59) != 0);
      if (!inst_req || i_acc) begin
        inst_req   = ($urandom_range(0, 9) < 6);
        inst_wr    = ($urandom_range(0, 3) == 0);
        inst_wstrb = 4'($urandom);
        inst_addr  = pick_addr();
        inst_wdata = $urandom;
      end
      if (!data_req || d_acc) begin
        data_req   = ($urandom_range(0, 9) < 7);
        data_wr    = ($urandom_range(0, 1) == 0);
        data_wstrb = 4'($urandom);
        data_addr  = pick_addr();
        data_wdata = $urandom;
      end
    end

    inst_req = 0; data_req = 0; resetn = 1;
    repeat (5) tick();
    chk("drain_queue_empty", 32'(exp_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_sram_arbiter.md
CPU_SRAM_ARBITER -- requirements
Module: cpu_sram_arbiter

Interface
REQ-001 SHALL have parameter STARVE_LIMIT, default 4, the number of consecutive data grants allowed while inst_req is pending.
REQ-002 SHALL have port clk  in  1  single clock; all state updates on rising edge.
REQ-003 SHALL have port resetn  in  1  reset, synchronous, active-low.
REQ-004 SHALL have ports inst_req / data_req  in  1  request valid; held with payload until matching addr_ok.
REQ-005 SHALL have ports inst_wr / data_wr  in  1  1 = write, 0 = read.
REQ-006 SHALL have ports inst_wstrb / data_wstrb  in  4  byte enables, used only when wr = 1.
REQ-007 SHALL have ports inst_addr / data_addr  in  32  physical byte address.
REQ-008 SHALL have ports inst_wdata / data_wdata  in  32  write data.
REQ-009 SHALL have ports inst_addr_ok / data_addr_ok  out  1  request accepted this cycle.
REQ-010 SHALL have ports inst_data_ok / data_data_ok  out  1  response valid this cycle.
REQ-011 SHALL have ports inst_rdata / data_rdata  out  32  read data, valid only with the matching data_ok.
REQ-012 SHALL have port sram_en  out  1  shared SRAM access enable.
REQ-013 SHALL have port sram_wen  out  4  shared SRAM byte write enables.
REQ-014 SHALL have port sram_addr  out  32  shared SRAM address.
REQ-015 SHALL have port sram_wdata  out  32  shared SRAM write data.
REQ-016 SHALL have port sram_rdata  in  32  SRAM read data, valid one cycle after sram_en.

Function
REQ-017 SHALL share one synchronous single-port SRAM (1-cycle read latency) between the inst and data requesters, issuing at most one access per cycle.
REQ-018 SHALL compute the grant combinationally each cycle: none if resetn = 0 or no req; the only requester if one; on a tie, data, unless starve_cnt == STARVE_LIMIT, then inst.
REQ-019 SHALL pulse addr_ok only for the granted requester, in the grant cycle; the other addr_ok stays 0; payloads are not latched.
REQ-020 SHALL drive on grant: sram_en = 1, sram_addr = granted addr, sram_wdata = granted wdata, sram_wen = wr ? wstrb : 4'b0.
REQ-021 SHALL drive with no grant: sram_en = 0, sram_wen = 0, sram_addr = 0, sram_wdata = 0.
REQ-022 SHALL implement the FSM IDLE / RESP_I / RESP_D, updated every cycle: grant inst -> RESP_I; grant data -> RESP_D; no grant -> IDLE; legal from every state.
REQ-023 SHALL assert inst_data_ok = 1 exactly in RESP_I and data_data_ok = 1 exactly in RESP_D (one cycle after grant, reads and writes alike); both 0 in IDLE.
REQ-024 SHALL drive inst_rdata = data_rdata = sram_rdata at all times; values are meaningful only with the matching data_ok.
REQ-025 SHALL support back-to-back operation: a new grant is allowed in a RESP cycle, giving a throughput of 1 access/cycle and a read latency of 1 cycle after addr_ok.
REQ-026 SHALL keep a starve_cnt of width clog2(STARVE_LIMIT+1): +1 on each data grant while inst_req = 1; cleared on an inst grant or when inst_req = 0; saturating at STARVE_LIMIT.
REQ-027 SHALL, when starve_cnt == STARVE_LIMIT and both requests are present, grant inst and clear starve_cnt in the same cycle.

Reset
REQ-028 SHALL, while resetn = 0 at a clock edge, set FSM = IDLE and starve_cnt = 0, hold all addr_ok = 0 and sram_en = 0, and hold sram_wen = 0.
REQ-029 SHALL discard an outstanding response on reset mid-operation: no data_ok in the cycle after reset is released.

Verification
REQ-030 SHALL verify the inst-only read: inst_req = 1, addr = 0xBFC00000 -> same cycle inst_addr_ok = 1 and sram_en = 1 with sram_addr = 0xBFC00000; next cycle inst_data_ok = 1 and inst_rdata = sram_rdata.
REQ-031 SHALL verify the data write: data_req = 1, wr = 1, wstrb = 4'b0011, wdata = 0x12345678 -> sram_wen = 4'b0011 and sram_wdata = 0x12345678; next cycle data_data_ok = 1 and inst_data_ok = 0.
REQ-032 SHALL verify the tie: both req = 1 with starve_cnt = 0 -> data_addr_ok = 1, inst_addr_ok = 0; next cycle FSM = RESP_D.
REQ-033 SHALL verify starvation: both req held continuously -> data is granted for 4 cycles, then inst on the 5th cycle, then data again with starve_cnt = 0.
REQ-034 SHALL verify back-to-back: data reads issued to addr A then B in consecutive cycles -> data_data_ok = 1 for two consecutive cycles, returning mem[A] then mem[B].
REQ-035 SHALL verify reset mid-operation: resetn = 0 in the RESP_I cycle after an inst grant -> all outputs 0 next cycle, and no inst_data_ok after release.
